// File: rtl/thee_clk_pkg.sv
// rtl/thee_clk_pkg.sv - shared state type, default width and clamp helper for the clock divider
package thee_clk_pkg;

  typedef enum logic [1:0] {CDG_IDLE, CDG_HIGH, CDG_LOW} cdg_state_e;

  localparam int unsigned CDG_CNT_W_DEF = 16;

  // A phase length of zero cannot be counted; treat it as the shortest legal phase.
  function automatic int unsigned clamp1(input int unsigned v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/thee_clk_div_gen_if.sv
// rtl/thee_clk_div_gen_if.sv - config valid/ready channel for the clock divider
interface thee_clk_div_gen_if import thee_clk_pkg::*; #(
  parameter int unsigned CNT_W = CDG_CNT_W_DEF
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;

  modport master (output cfg_valid, output cfg_high, output cfg_low, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_high, input cfg_low, output cfg_ready);
endinterface

// File: rtl/thee_clk_cfg_shadow.sv
// rtl/thee_clk_cfg_shadow.sv - one-deep holding register for configs accepted while the divider runs
module thee_clk_cfg_shadow import thee_clk_pkg::*; #(
  parameter int unsigned CNT_W = CDG_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic             hold,
  input  logic             consume,
  output logic             cfg_ready,
  output logic             pending,
  output logic [CNT_W-1:0] shadow_high,
  output logic [CNT_W-1:0] shadow_low
);
  logic accept;

  assign cfg_ready = !pending;
  assign accept    = cfg_valid & cfg_ready;

  // consume only fires with pending set, and accept only with pending clear, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      shadow_high <= CNT_W'(1);
      shadow_low  <= CNT_W'(1);
    end else begin
      if (consume) begin
        pending <= 1'b0;
      end
      if (accept && hold) begin
        pending     <= 1'b1;
        shadow_high <= CNT_W'(clamp1(32'(cfg_high)));
        shadow_low  <= CNT_W'(clamp1(32'(cfg_low)));
      end
    end
  end

endmodule

// File: rtl/thee_clk_div_gen.sv
// rtl/thee_clk_div_gen.sv - programmable high/low clock generator, new settings applied at period boundaries
// THEE_CLK_DIV_SYNC_STOP_EN: when defined, dropping en finishes the current period instead of stopping at once.
module thee_clk_div_gen import thee_clk_pkg::*; #(
  parameter int unsigned CNT_W    = CDG_CNT_W_DEF,
  parameter int unsigned DEF_HIGH = 1,
  parameter int unsigned DEF_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  thee_clk_div_gen_if.slave    cfg,
  output logic                 clk_out,
  output logic                 period_done,
  output logic                 busy
);

`ifdef THEE_CLK_DIV_SYNC_STOP_EN
  localparam bit SYNC_STOP = 1'b1;
`else
  localparam bit SYNC_STOP = 1'b0;
`endif

  cdg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_high;
  logic [CNT_W-1:0] act_low;
  logic [CNT_W-1:0] shadow_high;
  logic [CNT_W-1:0] shadow_low;
  logic [CNT_W-1:0] in_high;
  logic [CNT_W-1:0] in_low;
  logic [CNT_W-1:0] start_high;
  logic [CNT_W-1:0] next_high;
  logic [CNT_W-1:0] next_low;
  logic             pending;
  logic             accept;
  logic             idle_load;
  logic             boundary;
  logic             consume;

  assign busy       = (state != CDG_IDLE);
  assign accept     = cfg.cfg_valid & cfg.cfg_ready;
  assign idle_load  = accept & !busy;
  assign in_high    = CNT_W'(clamp1(32'(cfg.cfg_high)));
  assign in_low     = CNT_W'(clamp1(32'(cfg.cfg_low)));
  // A config accepted in the same cycle as the start must also size the first high phase.
  assign start_high = idle_load ? in_high : act_high;
  assign boundary   = (state == CDG_LOW) && (cnt == '0) && en;
  assign consume    = boundary & pending;
  assign next_high  = pending ? shadow_high : act_high;
  assign next_low   = pending ? shadow_low  : act_low;

  thee_clk_cfg_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg.cfg_valid),
    .cfg_high    (cfg.cfg_high),
    .cfg_low     (cfg.cfg_low),
    .hold        (busy),
    .consume     (consume),
    .cfg_ready   (cfg.cfg_ready),
    .pending     (pending),
    .shadow_high (shadow_high),
    .shadow_low  (shadow_low)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CDG_IDLE;
      clk_out     <= 1'b0;
      period_done <= 1'b0;
      cnt         <= '0;
      act_high    <= CNT_W'(clamp1(DEF_HIGH));
      act_low     <= CNT_W'(clamp1(DEF_LOW));
    end else begin
      period_done <= 1'b0;
      if (idle_load) begin
        act_high <= in_high;
        act_low  <= in_low;
      end
      unique case (state)
        CDG_IDLE: begin
          if (en) begin
            state   <= CDG_HIGH;
            clk_out <= 1'b1;
            cnt     <= start_high - CNT_W'(1);
          end
        end
        CDG_HIGH: begin
          if (!SYNC_STOP && !en) begin
            state   <= CDG_IDLE;
            clk_out <= 1'b0;
            cnt     <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state   <= CDG_LOW;
            clk_out <= 1'b0;
            cnt     <= act_low - CNT_W'(1);
          end
        end
        CDG_LOW: begin
          if (!SYNC_STOP && !en) begin
            state   <= CDG_IDLE;
            clk_out <= 1'b0;
            cnt     <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (boundary) begin
            act_high    <= next_high;
            act_low     <= next_low;
            state       <= CDG_HIGH;
            clk_out     <= 1'b1;
            cnt         <= next_high - CNT_W'(1);
            period_done <= 1'b1;
          end else begin
            state   <= CDG_IDLE;
            clk_out <= 1'b0;
            cnt     <= '0;
          end
        end
        default: begin
          state   <= CDG_IDLE;
          clk_out <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thee_clk_div_gen.sv
// tb/tb_thee_clk_div_gen.sv - randomized self-checking bench with a period-position reference model
module tb_thee_clk_div_gen;

  localparam int CNT_W = 16;
`ifdef THEE_CLK_DIV_SYNC_STOP_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clk_out;
  logic period_done;
  logic busy;

  thee_clk_div_gen_if #(.CNT_W(CNT_W)) cfg_if ();

  thee_clk_div_gen #(.CNT_W(CNT_W), .DEF_HIGH(1), .DEF_LOW(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg         (cfg_if),
    .clk_out     (clk_out),
    .period_done (period_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model: running flag plus position within the current period; clk_out is high for the first ah positions.
  bit m_run = 0;
  int m_pos = 0;
  int m_ah = 1;
  int m_al = 1;
  int m_sh = 1;
  int m_sl = 1;
  bit m_pend = 0;
  bit m_done = 0;

  function automatic int cl(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [3:0] exp_vec();
    return {(m_run && (m_pos < m_ah)), m_done, m_run, !m_pend};
  endfunction

  task automatic tick();
    bit acc;
    @(posedge clk);
    cyc++;
    acc = cfg_if.cfg_valid && !m_pend;
    m_done = 0;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_ah = 1; m_al = 1; m_pend = 0;
    end else if (!m_run) begin
      if (acc) begin
        m_ah = cl(int'(cfg_if.cfg_high));
        m_al = cl(int'(cfg_if.cfg_low));
      end
      if (en) begin
        m_run = 1; m_pos = 0;
      end
    end else begin
      m_pos++;
      if (!SYNC && !en) begin
        m_run = 0;
      end else if (m_pos == m_ah + m_al) begin
        if (en) begin
          if (m_pend) begin
            m_ah = m_sh; m_al = m_sl; m_pend = 0;
          end
          m_pos = 0;
          m_done = 1;
        end else begin
          m_run = 0;
        end
      end
      if (acc) begin
        m_sh = cl(int'(cfg_if.cfg_high));
        m_sl = cl(int'(cfg_if.cfg_low));
        m_pend = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cfg_if.cfg_valid = 1'b0; cfg_if.cfg_high = '0; cfg_if.cfg_low = '0;
    tick(); tick();
    n_total++;
    if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== 4'b0001)
      $display("FAIL reset_state: got %b want 0001", {clk_out, period_done, busy, cfg_if.cfg_ready});
    else n_pass++;
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL idle_hold cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_default();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL default_1_1 cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic go_idle(input string name);
    en = 1'b0;
    for (int i = 0; i < 40 && (busy || !cfg_if.cfg_ready); i++) tick();
    n_total++;
    if (busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1)
      $display("FAIL %s_idle_timeout: got busy=%b ready=%b want busy=0 ready=1", name, busy, cfg_if.cfg_ready);
    else n_pass++;
  endtask

  task automatic test_cfg_idle();
    int t_first;
    int t_second;
    int highs;
    go_idle("cfg_idle");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_high = 16'd3; cfg_if.cfg_low = 16'd5;
    tick();
    cfg_if.cfg_valid = 1'b0;
    en = 1'b1;
    t_first = -1; t_second = -1; highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL cfg_3_5 cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
      if (t_first >= 0 && t_second < 0 && !period_done && clk_out) highs++;
      if (period_done) begin
        if (t_first < 0) begin t_first = i; highs = 1; end
        else if (t_second < 0) t_second = i;
      end
    end
    n_total++;
    if (t_second - t_first !== 8 || highs !== 3)
      $display("FAIL period_3_5: got period %0d high %0d want period 8 high 3", t_second - t_first, highs);
    else n_pass++;
  endtask

  task automatic test_midrun();
    int gap;
    en = 1'b1;
    for (int i = 0; i < 20 && !period_done; i++) tick();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_high = 16'd2; cfg_if.cfg_low = 16'd2;
    tick();
    cfg_if.cfg_valid = 1'b0;
    n_total++;
    if (cfg_if.cfg_ready !== 1'b0 || clk_out !== 1'b1)
      $display("FAIL midrun_accept: got ready=%b clk_out=%b want ready=0 clk_out=1", cfg_if.cfg_ready, clk_out);
    else n_pass++;
    gap = 0;
    for (int i = 0; i < 20 && !period_done; i++) begin
      tick();
      gap++;
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL midrun_old cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
    end
    n_total++;
    if (gap !== 7 || cfg_if.cfg_ready !== 1'b1)
      $display("FAIL midrun_boundary: got gap %0d ready=%b want gap 7 ready=1", gap, cfg_if.cfg_ready);
    else n_pass++;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gap >= 0) gap++;
      if (period_done && gap > 0) begin
        n_total++;
        if (gap !== 4) $display("FAIL midrun_new_period: got %0d want 4", gap);
        else n_pass++;
        gap = -1;
      end
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL midrun_new cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_zero_cfg();
    en = 1'b1;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_high = '0; cfg_if.cfg_low = '0;
    for (int i = 0; i < 10 && !cfg_if.cfg_ready; i++) tick();
    tick();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL zero_cfg cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
    end
    n_total++;
    if (clk_out === period_done ? 1'b0 : 1'b1)
      $display("FAIL zero_cfg_period2: got clk_out=%b period_done=%b want equal", clk_out, period_done);
    else n_pass++;
  endtask

  task automatic test_stop();
    int busy_cycles;
    int high_cycles;
    go_idle("stop");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_high = 16'd4; cfg_if.cfg_low = 16'd4;
    tick();
    cfg_if.cfg_valid = 1'b0;
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    busy_cycles = 0; high_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL stop cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
      if (!busy) break;
      busy_cycles++;
      if (clk_out) high_cycles++;
    end
    n_total++;
    if (busy_cycles !== (SYNC ? 6 : 0) || high_cycles !== (SYNC ? 2 : 0))
      $display("FAIL stop_tail: got busy %0d high %0d want busy %0d high %0d",
               busy_cycles, high_cycles, SYNC ? 6 : 0, SYNC ? 2 : 0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_low();
    go_idle("rst_low");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_high = 16'd3; cfg_if.cfg_low = 16'd5;
    tick();
    en = 1'b1;
    tick();
    cfg_if.cfg_high = 16'd2; cfg_if.cfg_low = 16'd2;
    tick();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 10 && clk_out; i++) tick();
    tick();
    n_total++;
    if (clk_out !== 1'b0 || cfg_if.cfg_ready !== 1'b0)
      $display("FAIL rst_low_setup: got clk_out=%b ready=%b want 0 0", clk_out, cfg_if.cfg_ready);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; en = 1'b0;
    n_total++;
    if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== 4'b0001)
      $display("FAIL rst_low_state: got %b want 0001", {clk_out, period_done, busy, cfg_if.cfg_ready});
    else n_pass++;
    tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL rst_low_defaults cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) != 0);
      cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_high = 16'($urandom_range(0, 4));
      cfg_if.cfg_low = 16'($urandom_range(0, 4));
      tick();
      n_total++;
      if ({clk_out, period_done, busy, cfg_if.cfg_ready} !== exp_vec())
        $display("FAIL random cyc %0d: got %b want %b", cyc, {clk_out, period_done, busy, cfg_if.cfg_ready}, exp_vec());
      else n_pass++;
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_high = '0;
    cfg_if.cfg_low = '0;
    test_reset();
    test_default();
    test_cfg_idle();
    test_midrun();
    test_zero_cfg();
    test_stop();
    test_reset_mid_low();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
